// File: rtl/simple_dual_port_bram_pkg.sv
// rtl/simple_dual_port_bram_pkg.sv - shared constants for the block RAM primitive
package simple_dual_port_bram_pkg;

  localparam int BYTE_BITS = 8;

endpackage

// File: rtl/simple_dual_port_bram.sv
// rtl/simple_dual_port_bram.sv - simple dual-port RAM, synchronous write, registered read-first read
module simple_dual_port_bram
  import simple_dual_port_bram_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = BYTE_BITS,
  localparam int ADDR_BITS = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [COLS-1:0]      wr_data,
  output logic [COLS-1:0]      rd_data
);

  localparam logic [ADDR_BITS:0] ROWS_LIM = (ADDR_BITS + 1)'(ROWS);

  // Zero contents come from the configuration image, never from reset.
  logic [COLS-1:0] mem [ROWS] = '{default: '0};

  logic rd_ok;
  logic wr_ok;

  assign rd_ok = ({1'b0, rd_addr} < ROWS_LIM);
  assign wr_ok = ({1'b0, wr_addr} < ROWS_LIM);

  always_ff @(posedge clk) begin
    if (reset_n && wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Separate output register so the read is read-first against the array above.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_ok) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_simple_dual_port_bram.sv
// tb/tb_simple_dual_port_bram.sv - randomized and directed checks of two RAM geometries against array models
module tb_simple_dual_port_bram;

  localparam int CLOCK_PERIOD = 10;

  logic        clk;
  logic        reset_n;

  logic [0:0]  rd_addr0, wr_addr0;
  logic        wr_en0;
  logic [7:0]  wr_data0, rd_data0;

  logic [1:0]  rd_addr1, wr_addr1;
  logic        wr_en1;
  logic [15:0] wr_data1, rd_data1;

  int vectors;
  int miscompares;

  logic [7:0]  m0 [2];
  logic [15:0] m1 [3];

  simple_dual_port_bram u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_addr (rd_addr0),
    .wr_en   (wr_en0),
    .wr_addr (wr_addr0),
    .wr_data (wr_data0),
    .rd_data (rd_data0)
  );

  simple_dual_port_bram #(.ROWS(3), .COLS(16)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_addr (rd_addr1),
    .wr_en   (wr_en1),
    .wr_addr (wr_addr1),
    .wr_data (wr_data1),
    .rd_data (rd_data1)
  );

  initial clk = 1'b0;
  always #(CLOCK_PERIOD / 2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic on both instances; the model reads before it writes.
  task automatic step(input logic we0, input int wa0, input logic [7:0] wd0, input int ra0,
                      input logic we1, input int wa1, input logic [15:0] wd1, input int ra1,
                      input string tag);
    logic [7:0]  exp0;
    logic [15:0] exp1;
    wr_en0 = we0; wr_addr0 = 1'(wa0); wr_data0 = wd0; rd_addr0 = 1'(ra0);
    wr_en1 = we1; wr_addr1 = 2'(wa1); wr_data1 = wd1; rd_addr1 = 2'(ra1);
    exp0 = reset_n ? m0[ra0] : 8'h00;
    exp1 = (reset_n && ra1 < 3) ? m1[ra1] : 16'h0000;
    if (reset_n && we0) m0[wa0] = wd0;
    if (reset_n && we1 && wa1 < 3) m1[wa1] = wd1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "/d0"}, 32'(rd_data0), 32'(exp0));
    check({tag, "/d1"}, 32'(rd_data1), 32'(exp1));
  endtask

  task automatic idle_read(input int ra0, input int ra1, input string tag);
    step(1'b0, 0, 8'h00, ra0, 1'b0, 0, 16'h0000, ra1, tag);
  endtask

  task automatic reset_pulse(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check({tag, "/d0"}, 32'(rd_data0), 32'h0);
    check({tag, "/d1"}, 32'(rd_data1), 32'h0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 2; i++) m0[i] = 8'h00;
    for (int i = 0; i < 3; i++) m1[i] = 16'h0000;
    reset_n = 1'b0;
    wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0; rd_addr0 = '0;
    wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; rd_addr1 = '0;
    @(negedge clk);
    check("reset_d0", 32'(rd_data0), 32'h0);
    check("reset_d1", 32'(rd_data1), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    idle_read(0, 0, "untouched0");
    idle_read(1, 1, "untouched1");
    idle_read(0, 2, "untouched2");

    step(1'b1, 0, 8'h05, 0, 1'b1, 2, 16'h1234, 0, "wr5a");
    step(1'b1, 0, 8'h05, 0, 1'b1, 3, 16'hFFFF, 0, "wr5b");
    step(1'b1, 1, 8'h03, 0, 1'b0, 0, 16'h0000, 2, "wr3a");
    step(1'b1, 1, 8'h03, 0, 1'b0, 0, 16'h0000, 3, "wr3b");
    idle_read(1, 2, "rd1");
    idle_read(0, 3, "rd0");

    reset_pulse("async_rst");
    idle_read(0, 2, "rd_after_rst");

    step(1'b1, 1, 8'h09, 1, 1'b1, 2, 16'h5678, 2, "collide");
    idle_read(1, 2, "after_collide");

    reset_n = 1'b0;
    step(1'b1, 0, 8'hAA, 0, 1'b1, 2, 16'hAAAA, 2, "wr_in_rst");
    reset_n = 1'b1;
    idle_read(0, 2, "blocked_wr");

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_pulse("rand_rst");
      end
      step(1'($urandom), int'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 1)),
           1'($urandom), int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 3)),
           "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
